multiply_arbiter: RTL
=====================

# multiply_arbiter

Round-robin controller that time-shares one signed 32x32 multiplier and dequantizer between two FM-radio multiply streams. Requester 0 is pilot squaring; requester 1 is the L−R demodulation product. Each requester has two operand FIFOs (a, b) and one result FIFO. The block pops one operand pair from the granted requester, multiplies and dequantizes it, and pushes the result to that requester's output FIFO. It replaces the per-stream multipliers inside `multiply_top`-style wrappers.

## Interface
- DATA_SIZE, 32, operand/result width (signed, fixed-point)
- DATA_SIZE_2, 64, full product width
- QUANT_BITS, 10, fractional bits removed by dequantization
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- a_empty  in  2  per-requester empty flag of operand-a FIFO (first-word-fall-through)
- a_dout  in  2×DATA_SIZE  per-requester operand-a data, valid while !a_empty
- a_rd_en  out  2  per-requester pop of operand-a FIFO
- b_empty, b_dout, b_rd_en  as for operand a, for operand b
- out_full  in  2  per-requester full flag of result FIFO
- out_wr_en  out  2  per-requester push to result FIFO
- out_din  out  DATA_SIZE  result data, shared by both result FIFOs and qualified by out_wr_en
- grant  out  1  index of requester currently owned (last owned when idle)
- busy  out  1  high in any state other than S_IDLE

## Operation
- Eligibility: requester r is eligible when !a_empty[r] && !b_empty[r] && !out_full[r].
- Arbitration: round-robin. If both requesters are eligible, grant the one not granted last. After reset the priority pointer favours requester 0.
- FSM:
  - S_IDLE: if any requester is eligible, latch the grant. In the same cycle, combinationally assert a_rd_en[g] and b_rd_en[g], and capture a_dout[g] and b_dout[g] into operand registers. Go to S_MULT. Otherwise stay in S_IDLE.
  - S_MULT: register the DATA_SIZE_2 signed product of the operand registers. Go to S_WRITE.
  - S_WRITE: if !out_full[g], assert out_wr_en[g] with out_din = (product >>> QUANT_BITS)[DATA_SIZE-1:0], update the priority pointer, and go to S_IDLE. If out_full[g], hold in S_WRITE with out_wr_en low.
- Arithmetic:
  - Dequantization is an arithmetic right shift, so it floors toward −∞; there is no rounding.
  - Overflow truncates to the low DATA_SIZE bits; there is no saturation.
- rd_en and wr_en are never asserted for the non-granted requester. At most one pop pair and one push occur per cycle.
- out_din holds its last value when out_wr_en is low.

## Timing
- Reset values: a_rd_en=0, b_rd_en=0, out_wr_en=0, out_din=0, grant=0, busy=0. The FSM resets to S_IDLE and the operand and product registers to 0.
- Pop at cycle n gives push at cycle n+2 (3-cycle transaction). Peak throughput is 1 result per 3 cycles shared across both requesters.
- The eligibility check samples the empty/full flags in S_IDLE only. A requester that becomes eligible mid-transaction waits for the next S_IDLE.
- Both requesters eligible continuously: grants alternate 0,1,0,1…
- out_full[g] rising during S_MULT: the transaction stalls in S_WRITE and completes the cycle after out_full falls. No data is lost or duplicated.
- Reset asserted mid-transaction: all outputs drop immediately (asynchronous) and the in-flight operand pair is discarded; it has already been popped. After reset the FSM restarts in S_IDLE with requester 0 favoured.

## Structure
- Shared package multiply_arbiter_pkg holds:
  - the state enum (S_IDLE, S_MULT, S_WRITE);
  - QUANT_BITS and DATA_SIZE defaults;
  - a DEQUANTIZE function (arithmetic shift plus truncate), reused by the FM-radio filters.
- One sub-module, multiply_dequant, is natural: the registered signed product plus the dequantize slice. It is instantiated once in the arbiter.
- Arbitration and FSM live in the top.

## Test plan
- Single pair: req0 a=0x00000400, b=0x00000800 → out_wr_en[0] pulses 2 cycles after rd_en with out_din=0x00000800; req1 untouched.
- Signed/floor: req1 a=0xFFFFFC00, b=0x00000600 → 0xFFFFFA00; a=0xFFFFFFFF, b=0x00000001 → 0xFFFFFFFF.
- Fairness: both requesters preloaded with 8 pairs → grant sequence 0,1,0,1…; 16 pushes total; each output FIFO receives its 8 results in order.
- Backpressure: hold out_full[0]=1 after its first pop → the FSM holds in S_WRITE, and req1 is not served during the stall (no pop on req1). Release after 10 cycles → exactly one push of the pending result, then arbitration resumes.
- Ineligible: a_empty[1]=0 but b_empty[1]=1 → no rd_en on either req1 FIFO; req0 is served normally.
- Reset mid-op: assert reset in S_MULT → all outputs 0 the same cycle. After release, the next transaction is granted to requester 0 and the discarded pair never appears at the output.

Source files
------------

// File: rtl/multiply_arbiter_pkg.sv
// Shared types and arithmetic for the multiplier arbiter and the FM-radio filters.
package multiply_arbiter_pkg;

  localparam int DATA_SIZE   = 32;
  localparam int DATA_SIZE_2 = 64;
  localparam int QUANT_BITS  = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_WRITE
  } state_t;

  // Floors toward -inf (arithmetic shift) and wraps on overflow; no rounding, no saturation.
  function automatic logic [DATA_SIZE-1:0] DEQUANTIZE(input logic signed [DATA_SIZE_2-1:0] p);
    return DATA_SIZE'(p >>> QUANT_BITS);
  endfunction

endpackage

// File: rtl/multiply_dequant.sv
// Registered signed full-width product followed by the dequantize slice.
module multiply_dequant
  import multiply_arbiter_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  output logic [DATA_SIZE-1:0] result
);

  logic signed [DATA_SIZE_2-1:0] a_ext;
  logic signed [DATA_SIZE_2-1:0] b_ext;
  logic signed [DATA_SIZE_2-1:0] product;

  assign a_ext = {{DATA_SIZE{a[DATA_SIZE-1]}}, a};
  assign b_ext = {{DATA_SIZE{b[DATA_SIZE-1]}}, b};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      product <= '0;
    end else if (load) begin
      product <= a_ext * b_ext;
    end
  end

  assign result = DEQUANTIZE(product);

endmodule

// File: rtl/multiply_arbiter.sv
// Round-robin owner of one shared multiplier between two operand/result FIFO sets.
// state   | meaning
// S_IDLE  | pick an eligible requester, pop its operand pair
// S_MULT  | register the full-width product
// S_WRITE | push the dequantized result, stall while the result FIFO is full
module multiply_arbiter
  import multiply_arbiter_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                a_empty,
  input  logic [1:0][DATA_SIZE-1:0] a_dout,
  output logic [1:0]                a_rd_en,
  input  logic [1:0]                b_empty,
  input  logic [1:0][DATA_SIZE-1:0] b_dout,
  output logic [1:0]                b_rd_en,
  input  logic [1:0]                out_full,
  output logic [1:0]                out_wr_en,
  output logic [DATA_SIZE-1:0]      out_din,
  output logic                      grant,
  output logic                      busy
);

  state_t               state;
  state_t               state_nxt;
  logic                 grant_nxt;
  logic                 prio;
  logic                 prio_nxt;
  logic [1:0]           eligible;
  logic                 pop;
  logic                 push;
  logic [DATA_SIZE-1:0] op_a;
  logic [DATA_SIZE-1:0] op_b;
  logic [DATA_SIZE-1:0] result;
  logic [DATA_SIZE-1:0] last_out;

  assign eligible = ~a_empty & ~b_empty & ~out_full;

  // reset gates the idle pop so no FIFO is drained while the block is held in reset
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    prio_nxt  = prio;
    a_rd_en   = '0;
    b_rd_en   = '0;
    out_wr_en = '0;
    pop       = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (reset && (|eligible)) begin
          grant_nxt          = (&eligible) ? prio : eligible[1];
          pop                = 1'b1;
          a_rd_en[grant_nxt] = 1'b1;
          b_rd_en[grant_nxt] = 1'b1;
          state_nxt          = S_MULT;
        end
      end
      S_MULT: state_nxt = S_WRITE;
      S_WRITE: begin
        if (!out_full[grant]) begin
          push             = 1'b1;
          out_wr_en[grant] = 1'b1;
          prio_nxt         = ~grant;
          state_nxt        = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      grant    <= 1'b0;
      prio     <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      last_out <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      prio  <= prio_nxt;
      if (pop) begin
        op_a <= a_dout[grant_nxt];
        op_b <= b_dout[grant_nxt];
      end
      if (push) begin
        last_out <= result;
      end
    end
  end

  multiply_dequant u_mul (
    .clock  (clock),
    .reset  (reset),
    .load   (state == S_MULT),
    .a      (op_a),
    .b      (op_b),
    .result (result)
  );

  // result only reaches the shared bus on a push, so out_din holds between pushes
  assign out_din = push ? result : last_out;
  assign busy    = (state != S_IDLE);

endmodule
